sorted_vector_serializer: RTL

SORTED_VECTOR_SERIALIZER -- requirements
Module: sorted_vector_serializer

---
 rtl/sorted_vector_serializer_pkg.sv | 15 +
 rtl/sorted_vector_serializer_vector_buffer.sv | 88 ++++++++
 rtl/sorted_vector_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sorted_vector_serializer_pkg.sv
// -----------------------------------------------------------------------------
// sorting_network_pkg
// Shared definitions for the sorted vector serializer: the drop counter width
// and the serializer FSM state type.
// -----------------------------------------------------------------------------
package sorting_network_pkg;

    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage : sorting_network_pkg

// File: rtl/sorted_vector_serializer_vector_buffer.sv
// -----------------------------------------------------------------------------
// vector_buffer
// Circular buffer holding BUF_DEPTH whole vectors. It has one write port and one
// read port. The read port shows the vector at rd_ptr and also the vector in the
// slot after it, so the serializer can register the next element with no bubble
// when it moves on to the following vector.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset (pointers/count only)
//   wr_en_i          write wr_data_i into slot wr_ptr and advance wr_ptr
//   wr_data_i        vector to store
//   rd_adv_i         release slot rd_ptr and advance rd_ptr
//   rd_data_o        vector at rd_ptr
//   rd_next_data_o   vector at rd_ptr+1 (wrapped)
//   count_o          number of occupied slots
//   full_o, empty_o  occupancy flags
// -----------------------------------------------------------------------------
module vector_buffer #(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 10,
    parameter int BUF_DEPTH      = 2,
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         wr_en_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  wr_data_i,
    input  logic                                         rd_adv_i,
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  rd_data_o,
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  rd_next_data_o,
    output logic [CNT_W-1:0]                             count_o,
    output logic                                         full_o,
    output logic                                         empty_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] mem_q [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q,  count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_nxt = ptr_inc(rd_ptr_q);
        wr_ptr_d   = wr_en_i  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_adv_i ? rd_ptr_nxt        : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en_i, rd_adv_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o      = mem_q[rd_ptr_q];
    assign rd_next_data_o = mem_q[rd_ptr_nxt];
    assign count_o        = count_q;
    assign full_o         = (count_q == CNT_FULL);
    assign empty_o        = (count_q == '0);

endmodule : vector_buffer

// File: rtl/sorted_vector_serializer.sv
// -----------------------------------------------------------------------------
// sorted_vector_serializer
// Takes whole sorted vectors from the sorting network, one strobe per vector,
// buffers up to BUF_DEPTH of them, and sends the elements out one at a time in
// ascending index order with a valid/ready handshake. If a vector arrives while
// the buffer is full and no vector is finishing, that vector is dropped and
// overflow_o pulses for one cycle.
//
// Optional feature: define SORTED_SERIALIZER_DROP_CNT_EN to add drop_cnt_o, a
// saturating count of dropped vectors.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   data_i         sorted vector, element 0 smallest
//   data_valid_i   vector strobe (no backpressure upstream)
//   data_o         serial element (registered)
//   data_valid_o   data_o valid (registered, equals state==STREAM)
//   data_ready_i   downstream ready
//   data_last_o    data_o is element NUMBERS_AMOUNT-1
//   overflow_o     one-cycle pulse after a dropped vector
//   drop_cnt_o     saturating drop count (only with the macro)
// -----------------------------------------------------------------------------
module sorted_vector_serializer
    import sorting_network_pkg::*;
#(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 10,
    parameter int BUF_DEPTH      = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
    input  logic                                         data_valid_i,
    output logic [NUMBER_WIDTH-1:0]                      data_o,
    output logic                                         data_valid_o,
    input  logic                                         data_ready_i,
    output logic                                         data_last_o,
    output logic                                         overflow_o
`ifdef SORTED_SERIALIZER_DROP_CNT_EN
   ,output logic [DROP_CNT_WIDTH-1:0]                    drop_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUMBERS_AMOUNT);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUMBERS_AMOUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] rd_cur;
    logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] rd_next;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [NUMBER_WIDTH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic              ovf_q,   ovf_d;

    logic hs;
    logic last_hs;
    logic accept;
    logic drop;
    logic fresh;

    vector_buffer #(
        .NUMBER_WIDTH   (NUMBER_WIDTH),
        .NUMBERS_AMOUNT (NUMBERS_AMOUNT),
        .BUF_DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (accept),
        .wr_data_i      (data_i),
        .rd_adv_i       (last_hs),
        .rd_data_o      (rd_cur),
        .rd_next_data_o (rd_next),
        .count_o        (buf_count),
        .full_o         (buf_full),
        .empty_o        (buf_empty)
    );

    always_comb begin
        hs      = valid_q & data_ready_i;
        last_hs = hs & (idx_q == IDX_LAST);
        // A full buffer still takes a vector if a slot frees up this same cycle.
        accept  = data_valid_i & (~buf_full | last_hs);
        drop    = data_valid_i & ~accept;

        idx_d = idx_q;
        if (hs) begin
            idx_d = last_hs ? '0 : idx_q + IDX_W'(1);
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = STREAM;
            STREAM:  if (last_hs && (buf_count == CNT_ONE) && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The element to register next comes from the incoming vector when the
        // buffer has nothing else left to show; otherwise from the current slot,
        // or from the next slot when the current vector is finishing.
        fresh  = buf_empty | (last_hs & (buf_count == CNT_ONE));
        data_d = '0;
        if (state_d == STREAM) begin
            if (fresh) begin
                data_d = data_i[idx_d];
            end else if (last_hs) begin
                data_d = rd_next[idx_d];
            end else begin
                data_d = rd_cur[idx_d];
            end
        end

        valid_d = (state_d == STREAM);
        last_d  = valid_d & (idx_d == IDX_LAST);
        ovf_d   = drop;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign data_last_o  = last_q;
    assign overflow_o   = ovf_q;

`ifdef SORTED_SERIALIZER_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    // Drop counting is compiled out; overflow_o still reports each drop.
`endif

endmodule : sorted_vector_serializer
